fifo_rr_arb: RTL and testbench

FIFO_RR_ARB -- requirements
Module: fifo_rr_arb

---
 rtl/fifo_rr_arb.sv | 217 +++++++++++++++++++++
 tb/tb_fifo_rr_arb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rr_arb
//  Description : NUM_CLIENTS independent input FIFOs feeding one registered
//                output stage through an arbiter. ARB_MODE=0 gives
//                round-robin, ARB_MODE=1 gives fixed priority, lowest index
//                first. Each edge produces at most one grant.
//
//  Ports
//    clk         : single clock, rising-edge active
//    rst         : asynchronous, active-low reset
//    in_valid    : per-client push request
//    in_data     : per-client payload, client i at [i*DATA_WIDTH +: DATA_WIDTH]
//    in_ready    : per-client "FIFO not full", decoded from registered count
//    out_valid   : output register holds a granted word
//    out_data    : granted payload
//    out_src     : index of the client that sourced out_data
//    out_ready   : downstream accepts out_data
//    fifo_count  : per-client occupancy, client i at [i*CNT_W +: CNT_W]
//    err_drop    : sticky per-client flag, push attempted while full
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rr_arb #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CLIENTS = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int ARB_MODE    = 0
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [NUM_CLIENTS-1:0]                          in_valid,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]               in_data,
    output logic [NUM_CLIENTS-1:0]                          in_ready,
    output logic                                            out_valid,
    output logic [DATA_WIDTH-1:0]                           out_data,
    output logic [$clog2(NUM_CLIENTS)-1:0]                  out_src,
    input  logic                                            out_ready,
    output logic [NUM_CLIENTS*$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
    output logic [NUM_CLIENTS-1:0]                          err_drop
);

    localparam int SRC_W = $clog2(NUM_CLIENTS);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] c_full_cnt   = CNT_W'(FIFO_DEPTH);
    localparam logic [SRC_W-1:0] c_last_index = SRC_W'(NUM_CLIENTS - 1);

    // ------------------------------------------------------------------
    // Shared per-client status, filled in by the per-client generate
    // ------------------------------------------------------------------
    logic [NUM_CLIENTS-1:0]                 w_ready;
    logic [NUM_CLIENTS-1:0]                 w_nonempty;
    logic [NUM_CLIENTS-1:0]                 w_grant;
    logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] w_head;

    // Arbiter / output-stage signals
    logic                   w_open;
    logic                   w_any;
    logic                   w_grant_any;
    logic [SRC_W-1:0]       w_base;
    logic [SRC_W-1:0]       w_winner;
    logic                   w_hi_found;
    logic                   w_lo_found;
    logic [SRC_W-1:0]       w_hi_idx;
    logic [SRC_W-1:0]       w_lo_idx;

    logic                   r_out_valid;
    logic [DATA_WIDTH-1:0]  r_out_data;
    logic [SRC_W-1:0]       r_out_src;
    logic [NUM_CLIENTS-1:0] r_err_drop;

    // ------------------------------------------------------------------
    // Per-client FIFOs
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
        logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
        logic [PTR_W-1:0]      r_wr_ptr;
        logic [PTR_W-1:0]      r_rd_ptr;
        logic [CNT_W-1:0]      r_count;
        logic                  w_push;
        logic                  w_pop;

        // Readiness comes only from the registered count: a pop on the
        // same edge does not free a slot for an incoming word.
        assign w_ready[i]    = (r_count != c_full_cnt);
        assign w_nonempty[i] = (r_count != '0);
        assign w_head[i]     = r_mem[r_rd_ptr];
        assign w_push        = in_valid[i] & w_ready[i];
        assign w_pop         = w_grant[i];

        assign fifo_count[i*CNT_W +: CNT_W] = r_count;

        // Storage carries no reset; emptiness is defined by the count.
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        // Depth is a power of two, so the pointers wrap by overflow.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Search origin: round-robin pointer, or zero for fixed priority
    // ------------------------------------------------------------------
    if (ARB_MODE == 0) begin : g_rr_ptr
        logic [SRC_W-1:0] r_rr_ptr;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_rr_ptr <= '0;
            end else if (w_grant_any) begin
                r_rr_ptr <= (w_winner == c_last_index) ? '0
                                                       : w_winner + SRC_W'(1);
            end
        end

        assign w_base = r_rr_ptr;
    end else begin : g_fixed_prio
        assign w_base = '0;
    end

    // ------------------------------------------------------------------
    // Winner search. Clients are split into two bands: indices at or
    // above the origin ("hi") and indices below it ("lo"). Scanning
    // downwards leaves the lowest non-empty index of each band; the hi
    // band wins if it has any candidate, which is the cyclic order
    // starting at the origin without needing a modulo.
    // ------------------------------------------------------------------
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int j = NUM_CLIENTS - 1; j >= 0; j--) begin
            if (w_nonempty[j]) begin
                if (j >= int'(w_base)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = SRC_W'(j);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = SRC_W'(j);
                end
            end
        end
    end

    assign w_winner    = w_hi_found ? w_hi_idx : w_lo_idx;
    assign w_any       = w_hi_found | w_lo_found;
    assign w_open      = ~r_out_valid | out_ready;
    assign w_grant_any = w_open & w_any;

    always_comb begin
        w_grant = '0;
        for (int j = 0; j < NUM_CLIENTS; j++) begin
            w_grant[j] = w_grant_any && (w_winner == SRC_W'(j));
        end
    end

    // ------------------------------------------------------------------
    // Output register. When open and nothing is pending, only the valid
    // drops; data and source keep their last values.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_open) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_head[w_winner];
                r_out_src   <= w_winner;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Sticky drop flags: a request against a full FIFO loses its data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_drop <= '0;
        end else begin
            r_err_drop <= r_err_drop | (in_valid & ~w_ready);
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign err_drop  = r_err_drop;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rr_arb
//  Description : Self-checking bench. Two instances (round-robin and fixed
//                priority) share one stimulus stream; a queue-based
//                reference model predicts every output after every edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rr_arb;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int SW = 2;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  in_valid;
    logic [N*DW-1:0] in_data;
    logic          out_ready;

    logic [N-1:0]    rr_rdy,  fp_rdy;
    logic            rr_ov,   fp_ov;
    logic [DW-1:0]   rr_od,   fp_od;
    logic [SW-1:0]   rr_os,   fp_os;
    logic [N*CW-1:0] rr_cnt,  fp_cnt;
    logic [N-1:0]    rr_err,  fp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_rr_arb #(.DATA_WIDTH(DW), .NUM_CLIENTS(N), .FIFO_DEPTH(D), .ARB_MODE(0)) u_dut_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rr_rdy), .out_valid(rr_ov), .out_data(rr_od), .out_src(rr_os),
        .out_ready(out_ready), .fifo_count(rr_cnt), .err_drop(rr_err)
    );

    fifo_rr_arb #(.DATA_WIDTH(DW), .NUM_CLIENTS(N), .FIFO_DEPTH(D), .ARB_MODE(1)) u_dut_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(fp_rdy), .out_valid(fp_ov), .out_data(fp_od), .out_src(fp_os),
        .out_ready(out_ready), .fifo_count(fp_cnt), .err_drop(fp_err)
    );

    // ---------------- reference model (index 0 = round-robin, 1 = fixed) ----
    logic [DW-1:0] mq [2][N][$];
    int            m_ptr;
    logic          m_ov  [2];
    logic [DW-1:0] m_od  [2];
    int            m_os  [2];
    logic [N-1:0]  m_err [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < N; c++) mq[m][c].delete();
            m_ov[m]  = 1'b0;
            m_od[m]  = '0;
            m_os[m]  = 0;
            m_err[m] = '0;
        end
        m_ptr = 0;
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            int sz [N];
            bit open;
            int w;
            for (int c = 0; c < N; c++) sz[c] = mq[m][c].size();
            open = !m_ov[m] || out_ready;
            if (open) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m == 0) ? (m_ptr + k) % N : k;
                    if (w < 0 && sz[c] > 0) w = c;
                end
                if (w >= 0) begin
                    m_od[m] = mq[m][w].pop_front();
                    m_os[m] = w;
                    m_ov[m] = 1'b1;
                    if (m == 0) m_ptr = (w + 1) % N;
                end else begin
                    m_ov[m] = 1'b0;
                end
            end
            for (int c = 0; c < N; c++) begin
                if (in_valid[c]) begin
                    if (sz[c] < D) mq[m][c].push_back(in_data[c*DW +: DW]);
                    else           m_err[m][c] = 1'b1;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input int m, input logic ov, input logic [DW-1:0] od,
                              input logic [SW-1:0] os, input logic [N-1:0] rdy,
                              input logic [N*CW-1:0] cnt, input logic [N-1:0] err);
        chk($sformatf("m%0d out_valid", m), 32'(ov), 32'(m_ov[m]));
        chk($sformatf("m%0d out_data", m), od, m_od[m]);
        chk($sformatf("m%0d out_src", m), 32'(os), m_os[m]);
        for (int c = 0; c < N; c++) begin
            chk($sformatf("m%0d in_ready[%0d]", m, c), 32'(rdy[c]), 32'(mq[m][c].size() < D));
            chk($sformatf("m%0d fifo_count[%0d]", m, c), 32'(cnt[c*CW +: CW]), mq[m][c].size());
        end
        chk($sformatf("m%0d err_drop", m), 32'(err), 32'(m_err[m]));
    endtask

    task automatic check_all();
        check_inst(0, rr_ov, rr_od, rr_os, rr_rdy, rr_cnt, rr_err);
        check_inst(1, fp_ov, fp_od, fp_os, fp_rdy, fp_cnt, fp_err);
    endtask

    // One clock edge: DUT and model advance together, then compare.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // Reset asserted between edges; outputs must change before any edge.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic rand_data();
        for (int c = 0; c < N; c++) in_data[c*DW +: DW] = $urandom;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int got;
        int g3;

        rst = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        #3;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // Single client, one-cycle latency
        in_data[2*DW +: DW] = 32'hA5;
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        cycle();
        in_valid = '0;
        chk("sc_valid_e1", 32'(rr_ov), 32'd0);
        cycle();
        chk("sc_valid_e2", 32'(rr_ov), 32'd1);
        chk("sc_data_e2", rr_od, 32'hA5);
        chk("sc_src_e2", 32'(rr_os), 32'd2);
        cycle();
        chk("sc_valid_e3", 32'(rr_ov), 32'd0);

        // Round-robin order from a fresh pointer
        do_reset();
        for (int c = 0; c < N; c++) in_data[c*DW +: DW] = 32'h10 + c;
        in_valid = '1;
        cycle();
        in_valid = '0;
        for (int k = 0; k < N; k++) begin
            cycle();
            chk($sformatf("rr_valid%0d", k), 32'(rr_ov), 32'd1);
            chk($sformatf("rr_src%0d", k), 32'(rr_os), k);
        end
        in_valid = 4'b1010;
        cycle();
        in_valid = '0;
        cycle();
        chk("rr_refill_a", 32'(rr_os), 32'd1);
        cycle();
        chk("rr_refill_b", 32'(rr_os), 32'd3);
        repeat (3) cycle();

        // Backpressure: five stalled cycles, then drain
        in_valid = 4'b0110;
        rand_data(); cycle();
        rand_data(); cycle();
        in_valid  = '0;
        out_ready = 1'b0;
        repeat (5) cycle();
        out_ready = 1'b1;
        repeat (6) cycle();

        // Full / overflow on client 0
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 4'b0001;
            in_data[0 +: DW] = 32'h100 + k;
            cycle();
        end
        in_valid = '0;
        chk("ovf_count0", 32'(rr_cnt[0 +: CW]), 32'd4);
        chk("ovf_ready0", 32'(rr_rdy[0]), 32'd0);
        chk("ovf_err0", 32'(rr_err[0]), 32'd1);
        out_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 8; k++) begin
            if (rr_ov) begin
                chk($sformatf("ovf_drain%0d", got), rr_od, 32'h100 + got);
                got++;
            end
            cycle();
        end
        chk("ovf_drain_len", got, 32'd5);

        // Fixed priority: client 3 starved while client 0 keeps data
        do_reset();
        out_ready = 1'b1;
        g3 = 0;
        for (int k = 0; k < 40; k++) begin
            in_valid = 4'b1001;
            rand_data();
            cycle();
            if (fp_ov && fp_os == 2'd3) g3++;
        end
        in_valid = '0;
        chk("fp_client3_grants", g3, 32'd0);
        repeat (8) cycle();

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            in_valid  = N'($urandom);
            rand_data();
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Reset mid-operation with FIFOs partly full
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = N'($urandom);
            rand_data();
            cycle();
        end
        in_valid = '0;
        do_reset();
        chk("mrst_valid", 32'(rr_ov), 32'd0);
        chk("mrst_ready", 32'(rr_rdy), 32'hF);
        in_valid = 4'b0010;
        in_data[1*DW +: DW] = 32'hBEEF;
        out_ready = 1'b1;
        cycle();
        in_valid = '0;
        cycle();
        chk("mrst_post_data", rr_od, 32'hBEEF);
        chk("mrst_post_src", 32'(rr_os), 32'd1);
        cycle();
        chk("mrst_no_stale", 32'(rr_ov), 32'd0);

        for (int k = 0; k < 200; k++) begin
            in_valid  = N'($urandom);
            rand_data();
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
